// File: rtl/inv_mix_columns_seq_if.sv
// Valid/ready handshake bundle for the iterative AES InvMixColumns engine.
// Master drives the input state and consumes the result; slave is the engine.
interface inv_mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per clock, IDLE/BUSY/DONE.
// Optional INV_MIX_COLUMNS_FWD_EN adds a `fwd` port selecting the forward matrix.
module inv_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef INV_MIX_COLUMNS_FWD_EN
  input  logic                   fwd,
`endif
  inv_mix_columns_seq_if.slave   bus,
  output logic                   busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0][31:0] work_q, work_d;
  logic [3:0][31:0] out_q, out_d;
  logic [3:0][31:0] mixed;
  logic [1:0]       idx_q, idx_d;
  logic             last_grp;
  logic             fwd_sel;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Rows rotate: output row i takes coefficient k from input row i+k (mod 4).
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic fwd_m);
    logic [3:0][7:0] a, x2, x4, x8, o;
    logic [1:0]      j1, j2, j3;
    a = col;
    for (int i = 0; i < 4; i++) begin
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      j1 = 2'(i + 1);
      j2 = 2'(i + 2);
      j3 = 2'(i + 3);
      if (fwd_m)
        o[i] = x2[i] ^ (x2[j1] ^ a[j1]) ^ a[j2] ^ a[j3];
      else
        o[i] = (x8[i] ^ x4[i] ^ x2[i]) ^ (x8[j1] ^ x2[j1] ^ a[j1]) ^
               (x8[j2] ^ x4[j2] ^ a[j2]) ^ (x8[j3] ^ a[j3]);
    end
    return o;
  endfunction

`ifdef INV_MIX_COLUMNS_FWD_EN
  logic fwd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fwd_q <= 1'b0;
    else if (state_q == IDLE && bus.in_valid)
      fwd_q <= fwd;
  end

  assign fwd_sel = fwd_q;
`else
  assign fwd_sel = 1'b0;
`endif

  assign last_grp = (idx_q == 2'(4 - COLS_PER_CYCLE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      idx_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (last_grp)      state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The result register is loaded on the final group so DONE presents it stably.
  always_comb begin
    work_d = work_q;
    idx_d  = idx_q;
    out_d  = out_q;
    mixed  = work_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++)
      mixed[idx_q + 2'(g)] = mix_col(work_q[idx_q + 2'(g)], fwd_sel);
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.state_in;
          idx_d  = '0;
        end
      end
      BUSY: begin
        work_d = mixed;
        if (last_grp) begin
          idx_d = '0;
          out_d = mixed;
        end else begin
          idx_d = idx_q + 2'(COLS_PER_CYCLE);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    busy          = (state_q == BUSY);
    bus.state_out = out_q;
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: three instances (1, 2, 4 columns per
// cycle) run the same vectors in lockstep against hand-computed results.
module tb_inv_mix_columns_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic busy1, busy2, busy4;
  logic [127:0] t;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq_if b1 ();
  inv_mix_columns_seq_if b2 ();
  inv_mix_columns_seq_if b4 ();

`ifdef INV_MIX_COLUMNS_FWD_EN
  logic fwd;
`endif

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef INV_MIX_COLUMNS_FWD_EN
    .fwd(fwd),
`endif
    .bus(b1), .busy(busy1));

  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef INV_MIX_COLUMNS_FWD_EN
    .fwd(fwd),
`endif
    .bus(b2), .busy(busy2));

  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
`ifdef INV_MIX_COLUMNS_FWD_EN
    .fwd(fwd),
`endif
    .bus(b4), .busy(busy4));

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setInValid(input logic v, input logic [127:0] d);
    b1.in_valid = v; b2.in_valid = v; b4.in_valid = v;
    b1.state_in = d; b2.state_in = d; b4.state_in = d;
  endtask

  task automatic setOutReady(input logic r);
    b1.out_ready = r; b2.out_ready = r; b4.out_ready = r;
  endtask

  task automatic applyStimulus(input string tag, input logic [127:0] d);
    setInValid(1'b1, d);
    step();
    setInValid(1'b0, 128'h0);
    checkBit({tag, "_busy1"}, busy1, 1'b1);
    checkBit({tag, "_busy4"}, busy4, 1'b1);
  endtask

  task automatic runAndCheck(input string tag, input logic [127:0] exp);
    int lat1, lat2, lat4;
    lat1 = 0; lat2 = 0; lat4 = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (b1.out_valid && lat1 == 0) lat1 = n + 1;
      if (b2.out_valid && lat2 == 0) lat2 = n + 1;
      if (b4.out_valid && lat4 == 0) lat4 = n + 1;
    end
    checkInt({tag, "_lat1"}, lat1, 5);
    checkInt({tag, "_lat2"}, lat2, 3);
    checkInt({tag, "_lat4"}, lat4, 2);
    checkWord({tag, "_data1"}, b1.state_out, exp);
    checkWord({tag, "_data2"}, b2.state_out, exp);
    checkWord({tag, "_data4"}, b4.state_out, exp);
    checkBit({tag, "_busy_done"}, busy1, 1'b0);
  endtask

  task automatic releaseOutput(input string tag, input logic [127:0] exp);
    setOutReady(1'b1);
    step();
    setOutReady(1'b0);
    checkBit({tag, "_rdy1"}, b1.in_ready, 1'b1);
    checkBit({tag, "_rdy2"}, b2.in_ready, 1'b1);
    checkBit({tag, "_rdy4"}, b4.in_ready, 1'b1);
    checkBit({tag, "_ov1"}, b1.out_valid, 1'b0);
    checkWord({tag, "_held1"}, b1.state_out, exp);
  endtask

  initial begin
    rst_n = 1'b1;
    setInValid(1'b0, 128'h0);
    setOutReady(1'b0);
`ifdef INV_MIX_COLUMNS_FWD_EN
    fwd = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    checkBit("rst_in_ready", b1.in_ready, 1'b1);
    checkBit("rst_out_valid", b1.out_valid, 1'b0);
    checkBit("rst_busy", busy1, 1'b0);
    checkWord("rst_state_out", b1.state_out, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single column, known AES vector
    applyStimulus("col0", {96'h0, 32'hbca14d8e});
    runAndCheck("col0", {96'h0, 32'h455313db});
    releaseOutput("col0", {96'h0, 32'h455313db});

    applyStimulus("all9d", {4{32'h9d58dc9f}});
    runAndCheck("all9d", {4{32'h5c220af2}});
    releaseOutput("all9d", {4{32'h5c220af2}});

    applyStimulus("fix01", {4{32'h01010101}});
    runAndCheck("fix01", {4{32'h01010101}});
    releaseOutput("fix01", {4{32'h01010101}});

    applyStimulus("fixc6", {4{32'hc6c6c6c6}});
    runAndCheck("fixc6", {4{32'hc6c6c6c6}});
    releaseOutput("fixc6", {4{32'hc6c6c6c6}});

    // backpressure: DONE held, new input ignored
    applyStimulus("hold", {4{32'hd6d7d5d5}});
    runAndCheck("hold", {4{32'hd5d4d4d4}});
    for (int i = 0; i < 10; i++) begin
      if (i == 3) setInValid(1'b1, {96'h0, 32'hbca14d8e});
      if (i == 5) setInValid(1'b0, 128'h0);
      step();
      checkBit("hold_ov", b1.out_valid, 1'b1);
      checkBit("hold_rdy", b1.in_ready, 1'b0);
      checkWord("hold_data", b1.state_out, {4{32'hd5d4d4d4}});
    end
    checkWord("hold_data2", b2.state_out, {4{32'hd5d4d4d4}});
    checkWord("hold_data4", b4.state_out, {4{32'hd5d4d4d4}});
    releaseOutput("hold", {4{32'hd5d4d4d4}});
    checkBit("hold_ignored", busy1, 1'b0);

    // reset in the middle of BUSY (idx=2 for the one-column instance)
    applyStimulus("abort", {4{32'h9d58dc9f}});
    step();
    step();
    checkBit("abort_busy", busy1, 1'b1);
    rst_n = 1'b0;
    #1;
    checkBit("abort_rdy", b1.in_ready, 1'b1);
    checkBit("abort_ov", b1.out_valid, 1'b0);
    checkBit("abort_busy0", busy1, 1'b0);
    checkWord("abort_out1", b1.state_out, 128'h0);
    checkBit("abort_ov2", b2.out_valid, 1'b0);
    checkWord("abort_out2", b2.state_out, 128'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // mixed columns after the aborted run
    applyStimulus("mix", {32'h01010101, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e});
    runAndCheck("mix", {32'h01010101, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db});
    releaseOutput("mix", {32'h01010101, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db});

`ifdef INV_MIX_COLUMNS_FWD_EN
    fwd = 1'b1;
    applyStimulus("fwd", {96'h0, 32'h455313db});
    runAndCheck("fwd", {96'h0, 32'hbca14d8e});
    releaseOutput("fwd", {96'h0, 32'hbca14d8e});
    for (int k = 0; k < 20; k++) begin
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      fwd = 1'b1;
      applyStimulus("chain_f", r);
      repeat (8) step();
      t = b1.state_out;
      setOutReady(1'b1);
      step();
      setOutReady(1'b0);
      fwd = 1'b0;
      applyStimulus("chain_i", t);
      runAndCheck("chain_i", r);
      releaseOutput("chain_i", r);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
